// File: rtl/i2c_write_responder_if.sv
// i2c_write_responder_if
//   Bundles the I2C pin view and the received-byte outputs of the
//   write-only I2C target.
//
//   Ports (signals):
//     scl_i, sda_i      raw SCL / SDA pin state seen by the responder
//     sda_pull          1 = responder drives SDA low, 0 = released
//     data_out          last received payload byte
//     data_out_valid    one-cycle strobe qualifying data_out
//     data_out_is_cmd   1 = command byte, 0 = GDDRAM data byte
//     addressed         high from address ACK until STOP / repeated START
//     xfer_done         one-cycle strobe on STOP of an addressed transfer
//     byte_count        payload bytes in the current / most recent transfer
//
//   Modports: slave = the responder, master = the bus/system side.
//
//   Handshake: there is no backpressure. data_out is meaningful only in the
//   cycle data_out_valid is 1; the consumer must accept it in that cycle.
interface i2c_write_responder_if;
    logic        scl_i;
    logic        sda_i;
    logic        sda_pull;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic        data_out_is_cmd;
    logic        addressed;
    logic        xfer_done;
    logic [15:0] byte_count;

    modport slave (
        input  scl_i,
        input  sda_i,
        output sda_pull,
        output data_out,
        output data_out_valid,
        output data_out_is_cmd,
        output addressed,
        output xfer_done,
        output byte_count
    );

    modport master (
        output scl_i,
        output sda_i,
        input  sda_pull,
        input  data_out,
        input  data_out_valid,
        input  data_out_is_cmd,
        input  addressed,
        input  xfer_done,
        input  byte_count
    );
endinterface

// File: rtl/i2c_write_responder.sv
// i2c_write_responder
//   Write-only I2C target for an SSD1306-style display stream. After its own
//   address with the write bit it accepts one control byte (bit 6 selects
//   command vs. GDDRAM data for the whole transaction) and then presents every
//   following byte on data_out with a one-cycle strobe, ACKing each byte.
//
//   Ports:
//     clk       system clock, rising edge
//     rst       synchronous, active-high reset
//     bus       i2c_write_responder_if.slave (pins and byte outputs)
//     state_o   current FSM state, for observation only
//
//   Parameters:
//     ADDRESS   7-bit target address
//     SDA_HOLD  clk cycles from the detected SCL falling edge to a change of
//               sda_pull (must be at least 1)
module i2c_write_responder #(
    parameter logic [6:0]  ADDRESS  = 7'b0111100,
    parameter int unsigned SDA_HOLD = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    i2c_write_responder_if.slave       bus,
    output logic [2:0]                 state_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        CTRL     = 3'd3,
        CTRL_ACK = 3'd4,
        DATA     = 3'd5,
        DATA_ACK = 3'd6,
        IGNORE   = 3'd7
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(SDA_HOLD);

    // [0],[1] synchronizer, [2] delay flop used for edge detection
    logic [2:0]  scl_q, scl_d;
    logic [2:0]  sda_q, sda_d;

    state_t      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic        hold_val_q, hold_val_d;
    logic        ack_fall_q, ack_fall_d;
    logic        sda_pull_q, sda_pull_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        valid_q, valid_d;
    logic        is_cmd_q, is_cmd_d;
    logic        addressed_q, addressed_d;
    logic        xfer_done_q, xfer_done_d;
    logic [15:0] byte_count_q, byte_count_d;

    logic scl_s, scl_dly, sda_s, sda_dly;
    logic scl_rise, scl_fall, start_ev, stop_ev;

    assign scl_s   = scl_q[1];
    assign scl_dly = scl_q[2];
    assign sda_s   = sda_q[1];
    assign sda_dly = sda_q[2];

    assign scl_rise = scl_s & ~scl_dly;
    assign scl_fall = ~scl_s & scl_dly;
    // SCL must be high on both samples so an SDA change near an SCL edge is
    // not mistaken for START/STOP.
    assign start_ev = scl_s & scl_dly & sda_dly & ~sda_s;
    assign stop_ev  = scl_s & scl_dly & ~sda_dly & sda_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q        <= 3'b111;
            sda_q        <= 3'b111;
            state_q      <= IDLE;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 4'd0;
            hold_cnt_q   <= 8'd0;
            hold_val_q   <= 1'b0;
            ack_fall_q   <= 1'b0;
            sda_pull_q   <= 1'b0;
            data_out_q   <= 8'h00;
            valid_q      <= 1'b0;
            is_cmd_q     <= 1'b1;
            addressed_q  <= 1'b0;
            xfer_done_q  <= 1'b0;
            byte_count_q <= 16'd0;
        end else begin
            scl_q        <= scl_d;
            sda_q        <= sda_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            hold_val_q   <= hold_val_d;
            ack_fall_q   <= ack_fall_d;
            sda_pull_q   <= sda_pull_d;
            data_out_q   <= data_out_d;
            valid_q      <= valid_d;
            is_cmd_q     <= is_cmd_d;
            addressed_q  <= addressed_d;
            xfer_done_q  <= xfer_done_d;
            byte_count_q <= byte_count_d;
        end
    end

    always_comb begin
        scl_d        = {scl_q[1:0], bus.scl_i};
        sda_d        = {sda_q[1:0], bus.sda_i};
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        hold_val_d   = hold_val_q;
        ack_fall_d   = ack_fall_q;
        sda_pull_d   = sda_pull_q;
        data_out_d   = data_out_q;
        valid_d      = 1'b0;
        is_cmd_d     = is_cmd_q;
        addressed_d  = addressed_q;
        xfer_done_d  = 1'b0;
        byte_count_d = byte_count_q;

        // Delayed sda_pull update; the address ACK is what marks us addressed.
        if (hold_cnt_q != 8'd0) begin
            hold_cnt_d = hold_cnt_q - 8'd1;
            if (hold_cnt_q == 8'd1) begin
                sda_pull_d = hold_val_q;
                if (hold_val_q && state_q == ADDR_ACK) begin
                    addressed_d = 1'b1;
                end
            end
        end

        if (stop_ev) begin
            state_d     = IDLE;
            bit_cnt_d   = 4'd0;
            sda_pull_d  = 1'b0;
            hold_cnt_d  = 8'd0;
            addressed_d = 1'b0;
            xfer_done_d = addressed_q;
        end else if (start_ev) begin
            state_d      = ADDR;
            bit_cnt_d    = 4'd0;
            byte_count_d = 16'd0;
            sda_pull_d   = 1'b0;
            hold_cnt_d   = 8'd0;
            addressed_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR, CTRL, DATA: begin
                    // A full byte is evaluated the cycle after its 8th SCL
                    // rise, so the completed byte is wholly in shift_q.
                    if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d  = 4'd0;
                        ack_fall_d = 1'b0;
                        if (state_q == ADDR) begin
                            if (shift_q[7:1] == ADDRESS && !shift_q[0]) begin
                                state_d = ADDR_ACK;
                            end else begin
                                state_d = IGNORE;
                            end
                        end else if (state_q == CTRL) begin
                            is_cmd_d = ~shift_q[6];
                            state_d  = CTRL_ACK;
                        end else begin
                            data_out_d = shift_q;
                            valid_d    = 1'b1;
                            if (byte_count_q != 16'hFFFF) begin
                                byte_count_d = byte_count_q + 16'd1;
                            end
                            state_d = DATA_ACK;
                        end
                    end else if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                ADDR_ACK, CTRL_ACK, DATA_ACK: begin
                    // First fall ends bit 8: schedule the pull. Second fall
                    // ends the ACK clock: schedule the release and move on.
                    if (scl_fall) begin
                        hold_cnt_d = HOLD_LOAD;
                        if (!ack_fall_q) begin
                            ack_fall_d = 1'b1;
                            hold_val_d = 1'b1;
                        end else begin
                            ack_fall_d = 1'b0;
                            hold_val_d = 1'b0;
                            state_d    = (state_q == ADDR_ACK) ? CTRL : DATA;
                        end
                    end
                end
                default: begin
                    // IDLE and IGNORE wait for START or STOP only.
                end
            endcase
        end
    end

    assign bus.sda_pull        = sda_pull_q;
    assign bus.data_out        = data_out_q;
    assign bus.data_out_valid  = valid_q;
    assign bus.data_out_is_cmd = is_cmd_q;
    assign bus.addressed       = addressed_q;
    assign bus.xfer_done       = xfer_done_q;
    assign bus.byte_count      = byte_count_q;
    assign state_o             = state_q;

endmodule

// File: tb/tb_i2c_write_responder.sv
module tb_i2c_write_responder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i2c_write_responder_if bus();
    logic       scl_m;
    logic       sda_m;
    logic [2:0] dbg_state;

    // Open-drain SDA: master release/drive ANDed with the responder pull.
    assign bus.scl_i = scl_m;
    assign bus.sda_i = sda_m & ~bus.sda_pull;

    i2c_write_responder #(.ADDRESS(7'h3C), .SDA_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- scoreboard / monitor ----------------
    logic [8:0] exp_q[$];   // {is_cmd, byte}
    logic [8:0] exp_item;
    int strobe_cnt = 0;
    int xfer_cnt   = 0;
    int pull_cnt   = 0;
    int addr_cnt   = 0;

    always @(negedge clk) begin
        if (rst == 1'b0) begin
            if (bus.sda_pull === 1'b1)  pull_cnt++;
            if (bus.addressed === 1'b1) addr_cnt++;
            if (bus.xfer_done === 1'b1) xfer_cnt++;
            if (bus.data_out_valid === 1'b1) begin
                strobe_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL strobe_unexpected: got cmd=%0b byte=%02h, required no strobe",
                             bus.data_out_is_cmd, bus.data_out);
                end else begin
                    exp_item = exp_q.pop_front();
                    if ({bus.data_out_is_cmd, bus.data_out} !== exp_item) begin
                        n_fail++;
                        $display("FAIL strobe_data: got cmd=%0b byte=%02h, required cmd=%0b byte=%02h",
                                 bus.data_out_is_cmd, bus.data_out, exp_item[8], exp_item[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_clk(10);
        scl_m = 1'b1;
        wait_clk(20);
        sda_m = 1'b0;
        wait_clk(20);
        scl_m = 1'b0;
        wait_clk(10);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_clk(10);
        scl_m = 1'b1;
        wait_clk(20);
        sda_m = 1'b1;
        wait_clk(20);
    endtask

    // Data bit; the line must carry exactly what the master drives.
    task automatic send_bit(input logic b);
        sda_m = b;
        wait_clk(10);
        scl_m = 1'b1;
        wait_clk(10);
        n_checks++;
        if (bus.sda_i !== b) begin
            n_fail++;
            $display("FAIL bus_bit: got sda=%0b, required %0b", bus.sda_i, b);
        end
        wait_clk(10);
        scl_m = 1'b0;
        wait_clk(10);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1;
        wait_clk(10);
        scl_m = 1'b1;
        wait_clk(10);
        acked = (bus.sda_i === 1'b0);
        wait_clk(10);
        scl_m = 1'b0;
        wait_clk(10);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst   = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clk(4);
        n_checks++;
        if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d, required 0", dbg_state); end
        n_checks++;
        if (bus.sda_pull !== 1'b0) begin n_fail++; $display("FAIL reset_sda_pull: got %0b, required 0", bus.sda_pull); end
        n_checks++;
        if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %02h, required 00", bus.data_out); end
        n_checks++;
        if (bus.data_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b, required 0", bus.data_out_valid); end
        n_checks++;
        if (bus.data_out_is_cmd !== 1'b1) begin n_fail++; $display("FAIL reset_is_cmd: got %0b, required 1", bus.data_out_is_cmd); end
        n_checks++;
        if (bus.addressed !== 1'b0) begin n_fail++; $display("FAIL reset_addressed: got %0b, required 0", bus.addressed); end
        n_checks++;
        if (bus.xfer_done !== 1'b0) begin n_fail++; $display("FAIL reset_xfer_done: got %0b, required 0", bus.xfer_done); end
        n_checks++;
        if (bus.byte_count !== 16'd0) begin n_fail++; $display("FAIL reset_byte_count: got %0d, required 0", bus.byte_count); end
        rst = 1'b0;
        wait_clk(10);
    endtask

    task automatic test_cmd_write();
        logic [7:0] seq [4];
        logic ack;
        int s0, x0;
        seq = '{8'h78, 8'h00, 8'hAE, 8'hAF};
        s0 = strobe_cnt;
        x0 = xfer_cnt;
        exp_q.push_back({1'b1, 8'hAE});
        exp_q.push_back({1'b1, 8'hAF});
        i2c_start();
        for (int i = 0; i < 4; i++) begin
            send_byte(seq[i], ack);
            n_checks++;
            if (ack !== 1'b1) begin n_fail++; $display("FAIL cmd_ack[%0d]: got nack, required ack", i); end
            if (i == 0) begin
                n_checks++;
                if (bus.addressed !== 1'b1) begin n_fail++; $display("FAIL cmd_addressed: got %0b, required 1", bus.addressed); end
            end
        end
        i2c_stop();
        wait_clk(5);
        n_checks++;
        if (strobe_cnt - s0 != 2) begin n_fail++; $display("FAIL cmd_strobes: got %0d, required 2", strobe_cnt - s0); end
        n_checks++;
        if (xfer_cnt - x0 != 1) begin n_fail++; $display("FAIL cmd_xfer_done: got %0d cycles, required 1", xfer_cnt - x0); end
        n_checks++;
        if (bus.byte_count !== 16'd2) begin n_fail++; $display("FAIL cmd_byte_count: got %0d, required 2", bus.byte_count); end
        n_checks++;
        if (bus.addressed !== 1'b0) begin n_fail++; $display("FAIL cmd_addr_after_stop: got %0b, required 0", bus.addressed); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL cmd_queue: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_data_write();
        logic [7:0] seq [5];
        logic ack;
        int s0, x0;
        seq = '{8'h78, 8'h40, 8'hFF, 8'h00, 8'h81};
        s0 = strobe_cnt;
        x0 = xfer_cnt;
        exp_q.push_back({1'b0, 8'hFF});
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, 8'h81});
        i2c_start();
        for (int i = 0; i < 5; i++) begin
            send_byte(seq[i], ack);
            n_checks++;
            if (ack !== 1'b1) begin n_fail++; $display("FAIL data_ack[%0d]: got nack, required ack", i); end
        end
        i2c_stop();
        wait_clk(5);
        n_checks++;
        if (strobe_cnt - s0 != 3) begin n_fail++; $display("FAIL data_strobes: got %0d, required 3", strobe_cnt - s0); end
        n_checks++;
        if (xfer_cnt - x0 != 1) begin n_fail++; $display("FAIL data_xfer_done: got %0d cycles, required 1", xfer_cnt - x0); end
        n_checks++;
        if (bus.byte_count !== 16'd3) begin n_fail++; $display("FAIL data_byte_count: got %0d, required 3", bus.byte_count); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL data_queue: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_wrong_addr();
        logic [7:0] addrs [2];
        logic ack;
        int s0, x0, p0, a0;
        addrs = '{8'h7A, 8'h79};
        for (int k = 0; k < 2; k++) begin
            s0 = strobe_cnt; x0 = xfer_cnt; p0 = pull_cnt; a0 = addr_cnt;
            i2c_start();
            send_byte(addrs[k], ack);
            n_checks++;
            if (ack !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_ack %02h: got ack, required nack", addrs[k]); end
            send_byte(8'h00, ack);
            n_checks++;
            if (ack !== 1'b0) begin n_fail++; $display("FAIL wrong_ctrl_ack %02h: got ack, required nack", addrs[k]); end
            i2c_stop();
            wait_clk(5);
            n_checks++;
            if (pull_cnt != p0) begin n_fail++; $display("FAIL wrong_pull %02h: got %0d cycles, required 0", addrs[k], pull_cnt - p0); end
            n_checks++;
            if (addr_cnt != a0) begin n_fail++; $display("FAIL wrong_addressed %02h: got %0d cycles, required 0", addrs[k], addr_cnt - a0); end
            n_checks++;
            if (strobe_cnt != s0) begin n_fail++; $display("FAIL wrong_strobes %02h: got %0d, required 0", addrs[k], strobe_cnt - s0); end
            n_checks++;
            if (xfer_cnt != x0) begin n_fail++; $display("FAIL wrong_xfer %02h: got %0d, required 0", addrs[k], xfer_cnt - x0); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq1 [3];
        logic [7:0] seq2 [3];
        logic ack;
        int s0, x0;
        seq1 = '{8'h78, 8'h00, 8'hAE};
        seq2 = '{8'h78, 8'h40, 8'h55};
        s0 = strobe_cnt;
        x0 = xfer_cnt;
        exp_q.push_back({1'b1, 8'hAE});
        exp_q.push_back({1'b0, 8'h55});
        i2c_start();
        for (int i = 0; i < 3; i++) begin
            send_byte(seq1[i], ack);
            n_checks++;
            if (ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack1[%0d]: got nack, required ack", i); end
        end
        i2c_start();
        for (int i = 0; i < 3; i++) begin
            send_byte(seq2[i], ack);
            n_checks++;
            if (ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack2[%0d]: got nack, required ack", i); end
        end
        i2c_stop();
        wait_clk(5);
        n_checks++;
        if (strobe_cnt - s0 != 2) begin n_fail++; $display("FAIL b2b_strobes: got %0d, required 2", strobe_cnt - s0); end
        n_checks++;
        if (xfer_cnt - x0 != 1) begin n_fail++; $display("FAIL b2b_xfer_done: got %0d, required 1", xfer_cnt - x0); end
        n_checks++;
        if (bus.byte_count !== 16'd1) begin n_fail++; $display("FAIL b2b_byte_count: got %0d, required 1", bus.byte_count); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_queue: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_partial_byte();
        logic [7:0] pat;
        logic ack;
        int s0, x0;
        pat = 8'hA5;
        s0 = strobe_cnt;
        x0 = xfer_cnt;
        i2c_start();
        send_byte(8'h78, ack);
        n_checks++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL partial_addr_ack: got nack, required ack"); end
        send_byte(8'h00, ack);
        n_checks++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL partial_ctrl_ack: got nack, required ack"); end
        for (int i = 7; i >= 3; i--) send_bit(pat[i]);
        i2c_stop();
        wait_clk(5);
        n_checks++;
        if (strobe_cnt != s0) begin n_fail++; $display("FAIL partial_strobes: got %0d, required 0", strobe_cnt - s0); end
        n_checks++;
        if (bus.byte_count !== 16'd0) begin n_fail++; $display("FAIL partial_byte_count: got %0d, required 0", bus.byte_count); end
        n_checks++;
        if (xfer_cnt - x0 != 1) begin n_fail++; $display("FAIL partial_xfer_done: got %0d, required 1", xfer_cnt - x0); end
    endtask

    task automatic test_reset_in_ack();
        logic [7:0] seq [3];
        logic [7:0] mid;
        logic ack;
        int s0, x0, budget;
        seq = '{8'h78, 8'h00, 8'hAE};
        mid = 8'h12;
        s0 = strobe_cnt;
        x0 = xfer_cnt;
        exp_q.push_back({1'b1, 8'h12});
        i2c_start();
        send_byte(8'h78, ack);
        send_byte(8'h00, ack);
        for (int i = 7; i >= 0; i--) send_bit(mid[i]);
        sda_m = 1'b1;
        budget = 0;
        while (bus.sda_pull !== 1'b1 && budget < 30) begin
            wait_clk(1);
            budget++;
        end
        n_checks++;
        if (bus.sda_pull !== 1'b1) begin n_fail++; $display("FAIL rst_ack_window: got no pull within 30 cycles, required pull"); end
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        n_checks++;
        if (bus.sda_pull !== 1'b0) begin n_fail++; $display("FAIL rst_release: got sda_pull=%0b, required 0", bus.sda_pull); end
        // Finish the interrupted ACK clock; nobody should be pulling now.
        wait_clk(10 - budget > 0 ? 10 - budget : 1);
        scl_m = 1'b1;
        wait_clk(10);
        n_checks++;
        if (bus.sda_i !== 1'b1) begin n_fail++; $display("FAIL rst_ack_gone: got sda=%0b, required 1", bus.sda_i); end
        wait_clk(10);
        scl_m = 1'b0;
        wait_clk(10);
        send_byte(8'h34, ack);
        n_checks++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_ignored_byte: got ack, required nack"); end
        i2c_stop();
        wait_clk(5);
        n_checks++;
        if (xfer_cnt != x0) begin n_fail++; $display("FAIL rst_no_xfer: got %0d, required 0", xfer_cnt - x0); end
        exp_q.push_back({1'b1, 8'hAE});
        i2c_start();
        for (int i = 0; i < 3; i++) begin
            send_byte(seq[i], ack);
            n_checks++;
            if (ack !== 1'b1) begin n_fail++; $display("FAIL rst_recover_ack[%0d]: got nack, required ack", i); end
        end
        i2c_stop();
        wait_clk(5);
        n_checks++;
        if (strobe_cnt - s0 != 2) begin n_fail++; $display("FAIL rst_strobes: got %0d, required 2", strobe_cnt - s0); end
        n_checks++;
        if (xfer_cnt - x0 != 1) begin n_fail++; $display("FAIL rst_xfer_done: got %0d, required 1", xfer_cnt - x0); end
        n_checks++;
        if (bus.byte_count !== 16'd1) begin n_fail++; $display("FAIL rst_byte_count: got %0d, required 1", bus.byte_count); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rst_queue: got %0d left, required 0", exp_q.size()); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_cmd_write();
        test_data_write();
        test_wrong_addr();
        test_back_to_back();
        test_partial_byte();
        test_reset_in_ack();
        wait_clk(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_write_responder.md
I2C_WRITE_RESPONDER -- requirements
Module: i2c_write_responder

Interface
REQ-001 Parameter ADDRESS, default 7'b0111100, 7-bit target address this block responds to.
REQ-002 Parameter SDA_HOLD, default 4, number of clk cycles after the SCL falling edge before sda_pull changes.
REQ-003 clk  input  1  system clock; all logic is on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 scl_i  input  1  raw SCL pin state.
REQ-006 sda_i  input  1  raw SDA pin state.
REQ-007 sda_pull  output  1  1 = drive SDA low; 0 = release (high-Z at the pad).
REQ-008 data_out  output  8  last received payload byte.
REQ-009 data_out_valid  output  1  one-cycle strobe qualifying data_out.
REQ-010 data_out_is_cmd  output  1  1 = byte is an SSD1306 command (control byte 0x00); 0 = GDDRAM data (control byte 0x40).
REQ-011 addressed  output  1  high from ADDRESS+W ACK until STOP, repeated START, or reset.
REQ-012 xfer_done  output  1  one-cycle strobe on STOP ending an addressed transaction.
REQ-013 byte_count  output  16  payload bytes received in the current or most recent transaction.

Function
REQ-014 scl_i and sda_i each pass through a 2-flop synchronizer plus one delay flop; edges come from the synchronized and delayed pair; pin-to-event latency is exactly 3 clk cycles.
REQ-015 START = synchronized SDA falls while synchronized SCL is high; STOP = synchronized SDA rises while synchronized SCL is high.
REQ-016 Bits are sampled on synchronized SCL rising edges, MSB first, into an 8-bit shift register with a 4-bit bit counter.
REQ-017 States: IDLE, ADDR, ADDR_ACK, CTRL, CTRL_ACK, DATA, DATA_ACK, IGNORE.
REQ-018 START in any state goes to ADDR, clears the bit counter and byte_count, and deasserts addressed.
REQ-019 STOP in any state goes to IDLE and releases sda_pull; xfer_done pulses only if addressed was 1.
REQ-020 ADDR: after 8 bits, go to ADDR_ACK if byte[7:1]==ADDRESS and byte[0]==0; otherwise go to IGNORE and never assert sda_pull.
REQ-021 ACK timing: sda_pull rises SDA_HOLD cycles after the SCL falling edge that ends bit 8, and falls SDA_HOLD cycles after the SCL falling edge that ends the 9th (ACK) clock.
REQ-022 ADDR_ACK -> CTRL at the end of the ACK clock; addressed rises with sda_pull.
REQ-023 CTRL: latch bit 6 of the received byte as D/C# (data_out_is_cmd = ~bit6); always ACK; CTRL_ACK -> DATA; the control byte is not presented on data_out.
REQ-024 DATA: after 8 bits, load data_out, pulse data_out_valid in the same cycle, and increment byte_count (saturates at 16'hFFFF); always ACK via DATA_ACK, then return to DATA.
REQ-025 Continuation bit (control bit 7) is ignored; D/C# holds for the whole transaction.
REQ-026 A STOP or START mid-byte discards the partial byte: no data_out_valid, and byte_count is unchanged by the partial byte.
REQ-027 IGNORE holds sda_pull=0 and leaves only on START or STOP.
REQ-028 sda_pull is never asserted in any state other than the ACK windows.

Reset
REQ-029 While rst=1: state=IDLE, sda_pull=0, data_out=8'h00, data_out_valid=0, data_out_is_cmd=1, addressed=0, xfer_done=0, byte_count=0, shift register and bit counter cleared, synchronizers preset to 1.
REQ-030 Reset mid-transfer releases SDA in the next cycle; after reset the block ignores the bus until a fresh START.

Verification
REQ-031 START, 0x78, 0x00, 0xAE, 0xAF, STOP -> 4 ACKs; data_out_valid strobes 0xAE then 0xAF with is_cmd=1; xfer_done=1 for one cycle; byte_count=2.
REQ-032 START, 0x78, 0x40, 0xFF, 0x00, 0x81, STOP -> 3 strobes with is_cmd=0; byte_count=3.
REQ-033 START, 0x7A (address 0x3D) or 0x79 (read), 0x00, STOP -> sda_pull stays 0 throughout; no strobes; no xfer_done; addressed stays 0.
REQ-034 START, 0x78, 0x00, 0xAE, then repeated START, 0x78, 0x40, 0x55, STOP -> 0xAE strobed with is_cmd=1, 0x55 with is_cmd=0; byte_count=1.
REQ-035 START, 0x78, 0x00, then 5 bits of 0xA5, then STOP -> no strobe; byte_count=0; xfer_done pulses once.
REQ-036 rst for 1 cycle during an ACK window -> sda_pull=0 in the next cycle; following bytes are ignored until a new START, after which a full write succeeds.
